packet_transmitter: RTL and testbench

// Framer upstream of packet_receiver. Takes one parallel packet (dest + data) via a valid/ready handshake.

---
 rtl/packet_transmitter_if.sv | 41 ++++
 rtl/packet_transmitter.sv | 125 ++++++++++++
 tb/tb_packet_transmitter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/packet_transmitter_if.sv
// Packet transmitter bundle: parallel packet handshake plus framed link output.
// Latency: none (wires only).
// Backpressure: in_ready from the slave gates acceptance of in_valid.
//
// Ports (signals in the bundle):
//   in_valid  packet offered on in_dest/in_data
//   in_ready  transmitter can accept a packet this cycle
//   in_dest   destination byte, first body byte of the frame
//   in_data   payload, 8*DATA_BYTES wide, sent MSB byte first
//   out_byte  registered link byte, 0x00 when idle
//   busy      high in every cycle out_byte carries a frame byte
interface packet_transmitter_if #(
    parameter int DATA_BYTES = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              in_dest;
    logic [8*DATA_BYTES-1:0] in_data;
    logic [7:0]              out_byte;
    logic                    busy;

    // Packet source side
    modport master (
        output in_valid,
        output in_dest,
        output in_data,
        input  in_ready,
        input  out_byte,
        input  busy
    );

    // Transmitter side
    modport slave (
        input  in_valid,
        input  in_dest,
        input  in_data,
        output in_ready,
        output out_byte,
        output busy
    );
endinterface

// File: rtl/packet_transmitter.sv
// Byte-stream framer: FLAG, dest, data MSB-first, FLAG; body FLAG/ESC bytes escaped.
// Latency: accept in cycle N -> opening FLAG on out_byte in cycle N+1.
// Backpressure: in_ready only while idle; in_valid held during a frame waits.
//
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-high reset
//   bus   packet_transmitter_if.slave (in_valid/in_ready/in_dest/in_data in,
//         out_byte/busy out)
module packet_transmitter #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] FLAG       = 8'h7E,
    parameter logic [7:0] ESC        = 8'h7D
) (
    input  logic                 clk,
    input  logic                 rst,
    packet_transmitter_if.slave  bus
);
    localparam int BODY_BYTES = DATA_BYTES + 1;
    localparam int SR_W       = 8 * BODY_BYTES;
    localparam int IDX_W      = $clog2(DATA_BYTES + 2);

    // The state names what out_byte is showing in the current cycle:
    //   ST_IDLE  0x00 on the line
    //   ST_SOF   opening FLAG
    //   ST_BODY  a body byte (plain, or the XORed half of an escape pair)
    //   ST_ESCB  the ESC prefix; the byte it escapes is still at the top of sreg
    //   ST_EOF   closing FLAG
    // Keeping the output register and the state in lockstep gives the
    // one-cycle accept-to-FLAG latency with a fully registered link byte.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_BODY,
        ST_ESCB,
        ST_EOF
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        out_q, out_d;
    logic [IDX_W-1:0]  idx_q, idx_d;      // body bytes fully sent
    logic [SR_W-1:0]   sreg_q, sreg_d;    // {dest, data}, top byte is next to send

    logic [7:0] cur;
    logic       body_done;
    logic       cur_special;

    assign cur         = sreg_q[SR_W-1 -: 8];
    assign body_done   = (idx_q == IDX_W'(BODY_BYTES));
    assign cur_special = (cur == FLAG) || (cur == ESC);

    always_comb begin
        state_d = state_q;
        out_d   = 8'h00;
        idx_d   = idx_q;
        sreg_d  = sreg_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_SOF;
                    out_d   = FLAG;
                    sreg_d  = {bus.in_dest, bus.in_data};
                    idx_d   = '0;
                end
            end

            // After the opening flag or a finished body byte, pick the next
            // body byte, or close the frame once every body byte is out.
            ST_SOF, ST_BODY: begin
                if (body_done) begin
                    state_d = ST_EOF;
                    out_d   = FLAG;
                end else if (cur_special) begin
                    // Hold cur in place; it goes out XORed on the next cycle.
                    state_d = ST_ESCB;
                    out_d   = ESC;
                end else begin
                    state_d = ST_BODY;
                    out_d   = cur;
                    sreg_d  = sreg_q << 8;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end

            ST_ESCB: begin
                state_d = ST_BODY;
                out_d   = cur ^ 8'h20;
                sreg_d  = sreg_q << 8;
                idx_d   = idx_q + IDX_W'(1);
            end

            ST_EOF: begin
                // Always return through IDLE so at least one 0x00 separates
                // frames and flags are never shared.
                state_d = ST_IDLE;
                out_d   = 8'h00;
            end

            default: begin
                state_d = ST_IDLE;
                out_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= 8'h00;
            idx_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.out_byte = out_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// Testbench for packet_transmitter: directed frames, back-to-back, mid-frame reset, random packets.
// Latency: outputs sampled on the falling edge, half a cycle after each update.
// Backpressure: waits on in_ready are bounded; a timeout counts as a failed check.
module tb_packet_transmitter;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    packet_transmitter_if #(.DATA_BYTES(4)) bus ();

    packet_transmitter #(.DATA_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Watchdog: the run must always end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference frame: flag, escaped body bytes, flag.
    task automatic build_frame(input logic [7:0] d, input logic [31:0] data, output bq_t q);
        logic [7:0] body[5];
        q = {};
        body[0] = d;
        for (int i = 0; i < 4; i++) body[i+1] = data[31-8*i -: 8];
        q.push_back(8'h7E);
        for (int i = 0; i < 5; i++) begin
            if (body[i] == 8'h7E || body[i] == 8'h7D) begin
                q.push_back(8'h7D);
                q.push_back(body[i] ^ 8'h20);
            end else begin
                q.push_back(body[i]);
            end
        end
        q.push_back(8'h7E);
    endtask

    // Called on a falling edge where the opening flag should be showing.
    task automatic check_frame(input bq_t q, input string tag);
        for (int i = 0; i < q.size(); i++) begin
            chk8($sformatf("%s_byte%0d", tag, i), bus.out_byte, q[i]);
            chk1($sformatf("%s_busy%0d", tag, i), bus.busy, 1'b1);
            chk1($sformatf("%s_rdy%0d", tag, i), bus.in_ready, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        chk8({tag, "_idle_byte"}, bus.out_byte, 8'h00);
        chk1({tag, "_idle_busy"}, bus.busy, 1'b0);
        chk1({tag, "_idle_rdy"}, bus.in_ready, 1'b1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_ready_wait"}, bus.in_ready, 1'b1);
    endtask

    // Offer a packet, check the accept cycle, the whole frame and the idle byte after.
    task automatic send_pkt(input logic [7:0] d, input logic [31:0] data, input string tag);
        bq_t q;
        build_frame(d, data, q);
        bus.in_dest  = d;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        wait_ready(tag);
        chk8({tag, "_accept_byte"}, bus.out_byte, 8'h00);
        @(negedge clk);
        // Scramble the inputs: the frame must come from the captured copy.
        bus.in_valid = 1'b0;
        bus.in_dest  = 8'($urandom);
        bus.in_data  = $urandom;
        check_frame(q, tag);
        check_idle(tag);
    endtask

    function automatic logic [7:0] rbyte();
        case ($urandom_range(0, 3))
            0:       return 8'h7E;
            1:       return 8'h7D;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        bq_t qa;
        bq_t qb;
        bus.in_valid = 1'b0;
        bus.in_dest  = 8'h00;
        bus.in_data  = 32'h0;

        // Reset state while reset is held
        #3;
        chk8("reset_byte", bus.out_byte, 8'h00);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_rdy", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // Plain frame, escaped frames, maximum-length frame
        send_pkt(8'h11, 32'h22334455, "t1_plain");
        send_pkt(8'h7E, 32'h7D445500, "t2_escape");
        send_pkt(8'h7E, 32'h7E7E7D7D, "t3_maxlen");

        // Back-to-back with in_valid held high across the first frame
        build_frame(8'hA1, 32'h7E0102B3, qa);
        build_frame(8'hC4, 32'hD5E67DF7, qb);
        bus.in_dest  = 8'hA1;
        bus.in_data  = 32'h7E0102B3;
        bus.in_valid = 1'b1;
        wait_ready("t4_a");
        chk8("t4_a_accept_byte", bus.out_byte, 8'h00);
        @(negedge clk);
        bus.in_dest = 8'hC4;
        bus.in_data = 32'hD5E67DF7;
        check_frame(qa, "t4_a");
        // Exactly one idle byte, during which the second packet is taken
        check_idle("t4_gap");
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_dest  = 8'h5A;
        bus.in_data  = 32'hDEADBEEF;
        check_frame(qb, "t4_b");
        check_idle("t4_b");

        // Reset on the third body byte
        @(negedge clk);
        bus.in_dest  = 8'hAA;
        bus.in_data  = 32'hBBCCDDEE;
        bus.in_valid = 1'b1;
        wait_ready("t5");
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk8("t5_flag", bus.out_byte, 8'h7E);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk8("t5_body3", bus.out_byte, 8'hCC);
        rst = 1'b1;
        #1;
        chk8("t5_rst_byte", bus.out_byte, 8'h00);
        chk1("t5_rst_busy", bus.busy, 1'b0);
        chk1("t5_rst_rdy", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_pkt(8'h01, 32'h02030405, "t5_after");

        // Random packets with FLAG/ESC heavily represented and random gaps
        for (int n = 0; n < 300; n++) begin
            logic [7:0]  d;
            logic [31:0] data;
            int          gap;
            d    = rbyte();
            data = {rbyte(), rbyte(), rbyte(), rbyte()};
            gap  = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            send_pkt(d, data, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
